// File: rtl/videofetch_fifo_pkg.sv
// Shared definitions for the video fetch FIFO: read-FSM encoding, byte-lane
// positions of the four pixel bit planes and default parameter values.
package videofetch_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned RED_LSB    = 0;
  localparam int unsigned GREEN_LSB  = 8;
  localparam int unsigned BLUE_LSB   = 16;
  localparam int unsigned BRIGHT_LSB = 24;

  localparam int unsigned DEF_ADDR_BITS      = 30;
  localparam int unsigned DEF_FIFO_ADDR_BITS = 4;
  localparam int unsigned DEF_WORDS_PER_LINE = 80;

endpackage

// File: rtl/videofetch_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, 2^fifo_addr_bits words.
module videofetch_fifo_ram
  import videofetch_fifo_pkg::*;
#(
  parameter int unsigned fifo_addr_bits = DEF_FIFO_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [fifo_addr_bits-1:0] waddr,
  input  logic [31:0]               wdata,
  input  logic [fifo_addr_bits-1:0] raddr,
  output logic [31:0]               rdata
);

  logic [31:0] mem [0:(1 << fifo_addr_bits)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/videofetch_fifo.sv
// Prefetches video words from memory into a small FIFO and hands the head
// word to the video stage as four 8-pixel bit planes.
module videofetch_fifo
  import videofetch_fifo_pkg::*;
#(
  parameter int unsigned addr_bits      = DEF_ADDR_BITS,
  parameter int unsigned fifo_addr_bits = DEF_FIFO_ADDR_BITS,
  parameter int unsigned words_per_line = DEF_WORDS_PER_LINE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_bits-1:0] base_addr,
  input  logic                 vsync,
  input  logic                 line_repeat,
  input  logic                 fetch_next,
  output logic [7:0]           red_byte,
  output logic [7:0]           green_byte,
  output logic [7:0]           blue_byte,
  output logic [7:0]           bright_byte,
  output logic [addr_bits-1:0] mem_addr,
  output logic                 mem_strobe,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_data,
  output logic                 underrun
);

  localparam int unsigned CW = fifo_addr_bits + 1;
  localparam int unsigned LW = (words_per_line > 1) ? $clog2(words_per_line) : 1;
  localparam logic [LW-1:0]        LAST_WORD   = LW'(words_per_line - 1);
  localparam logic [addr_bits-1:0] LINE_STRIDE = addr_bits'(words_per_line);

  fetch_state_t              state;
  logic                      vsync_q, repeat_q;
  logic                      vsync_rise, repeat_rise, flush;
  logic                      push, pop, empty;
  logic [CW-1:0]             count, count_next;
  logic [fifo_addr_bits-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]             line_word, pop_word;
  logic [addr_bits-1:0]      fetch_addr, disp_line_start;
  logic [31:0]               head;

  videofetch_fifo_ram #(.fifo_addr_bits(fifo_addr_bits)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (mem_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    vsync_rise  = vsync & ~vsync_q;
    repeat_rise = line_repeat & ~repeat_q;
    flush       = vsync_rise | repeat_rise;
    empty       = (count == '0);
    push        = (state == ST_REQ) & mem_ready & ~flush;
    pop         = fetch_next & ~empty & ~flush;
    count_next  = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    red_byte    = '0;
    green_byte  = '0;
    blue_byte   = '0;
    bright_byte = '0;
    if (!empty) begin
      red_byte    = head[RED_LSB +: 8];
      green_byte  = head[GREEN_LSB +: 8];
      blue_byte   = head[BLUE_LSB +: 8];
      bright_byte = head[BRIGHT_LSB +: 8];
    end
  end

  // FIFO bookkeeping, address tracking and underrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q         <= 1'b0;
      repeat_q        <= 1'b0;
      underrun        <= 1'b0;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      line_word       <= '0;
      pop_word        <= '0;
      fetch_addr      <= '0;
      disp_line_start <= '0;
    end else begin
      vsync_q  <= vsync;
      repeat_q <= line_repeat;
      if (vsync_rise)
        underrun <= 1'b0;
      else if (!flush && fetch_next && empty)
        underrun <= 1'b1;

      if (flush) begin
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        line_word <= '0;
        pop_word  <= '0;
        if (vsync_rise) begin
          fetch_addr      <= base_addr;
          disp_line_start <= base_addr;
        end else begin
          fetch_addr      <= disp_line_start - LINE_STRIDE;
          disp_line_start <= disp_line_start - LINE_STRIDE;
        end
      end else begin
        count <= count_next;
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          fetch_addr <= fetch_addr + 1'b1;
          line_word  <= (line_word == LAST_WORD) ? '0 : line_word + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (pop_word == LAST_WORD) begin
            pop_word        <= '0;
            disp_line_start <= disp_line_start + LINE_STRIDE;
          end else begin
            pop_word <= pop_word + 1'b1;
          end
        end
      end
    end
  end

  // Read FSM; an IDLE flush waits one cycle so the request uses the new address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_strobe <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && !count[fifo_addr_bits]) begin
            state      <= ST_REQ;
            mem_strobe <= 1'b1;
            mem_addr   <= fetch_addr;
          end
        end
        ST_REQ: begin
          if (flush) begin
            if (mem_ready) begin
              state      <= ST_IDLE;
              mem_strobe <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (mem_ready) begin
            if (!count_next[fifo_addr_bits]) begin
              mem_addr <= fetch_addr + 1'b1;
            end else begin
              state      <= ST_IDLE;
              mem_strobe <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_ready) begin
            state      <= ST_IDLE;
            mem_strobe <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          mem_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_videofetch_fifo.sv
// Self-checking bench for videofetch_fifo: directed sequences, a pop table and
// a randomized run against a queue-based reference model.
module tb_videofetch_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] base_addr;
  logic        vsync, line_repeat, fetch_next;
  logic [7:0]  red_byte, green_byte, blue_byte, bright_byte;
  logic [29:0] mem_addr;
  logic        mem_strobe, mem_ready;
  logic [31:0] mem_data;
  logic        underrun;

  always #5 clk = ~clk;

  videofetch_fifo #(
    .addr_bits      (30),
    .fifo_addr_bits (4),
    .words_per_line (80)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .base_addr   (base_addr),
    .vsync       (vsync),
    .line_repeat (line_repeat),
    .fetch_next  (fetch_next),
    .red_byte    (red_byte),
    .green_byte  (green_byte),
    .blue_byte   (blue_byte),
    .bright_byte (bright_byte),
    .mem_addr    (mem_addr),
    .mem_strobe  (mem_strobe),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .underrun    (underrun)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] q[$];
  bit          m_under, vprev, lrprev, m_pending;
  logic [29:0] m_line, m_fetch;
  int          m_popcnt, m_pops;
  bit          prev_strobe, prev_hs;
  logic [29:0] prev_addr;
  int          hs_count;
  bit          seen110;

  // memory responder controls
  int lat = 0;
  int wait_cnt = 0;
  bit mem_hold = 0;
  bit pop_on_ack = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never seen (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'h44, b + 8'h33, b + 8'h22, b + 8'h11};
  endfunction

  function automatic logic [31:0] head_word();
    return {bright_byte, blue_byte, green_byte, red_byte};
  endfunction

  task automatic check_outputs();
    logic [31:0] h;
    h = (q.size() > 0) ? q[0] : 32'h0;
    chk("head_word", head_word(), h);
    chk("underrun", underrun, m_under);
    if (q.size() == 16) chk("strobe_low_when_full", mem_strobe, 1'b0);
    if (prev_strobe && !prev_hs) begin
      chk("strobe_held", mem_strobe, 1'b1);
      chk("addr_stable", mem_addr, prev_addr);
    end
  endtask

  // One clock: check at negedge, drive inputs, advance model, wait next negedge.
  task automatic step(input bit v, input bit lr, input bit pop);
    bit hs, vr, lrr;
    int presize;
    check_outputs();
    if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_strobe && !mem_hold) begin
      if (wait_cnt >= lat) begin
        mem_ready = 1'b1;
        mem_data  = word_of(mem_addr);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    vsync       = v;
    line_repeat = lr;
    fetch_next  = pop_on_ack ? (mem_strobe && mem_ready) : pop;

    hs  = mem_strobe && mem_ready;
    vr  = v && !vprev;
    lrr = lr && !lrprev;
    vprev  = v;
    lrprev = lr;
    if (vr || lrr) begin
      q.delete();
      m_popcnt = 0;
      m_pops   = 0;
      if (vr) begin
        m_under = 1'b0;
        m_line  = base_addr;
      end else begin
        m_line = m_line - 30'd80;
      end
      m_fetch   = m_line;
      m_pending = mem_strobe && !mem_ready;
    end else begin
      presize = q.size();
      if (fetch_next) begin
        if (q.size() == 0) m_under = 1'b1;
        else begin
          void'(q.pop_front());
          m_pops++;
          m_popcnt++;
          if (m_popcnt == 80) begin
            m_popcnt = 0;
            m_line   = m_line + 30'd80;
          end
        end
      end
      if (hs) begin
        if (m_pending) m_pending = 1'b0;
        else begin
          chk("fetch_addr", mem_addr, m_fetch);
          chk("no_overflow", presize < 16, 1'b1);
          q.push_back(word_of(mem_addr));
          m_fetch = m_fetch + 30'd1;
          hs_count++;
          if (mem_addr == 30'h110) seen110 = 1'b1;
        end
      end
    end
    prev_strobe = mem_strobe;
    prev_hs     = hs;
    prev_addr   = mem_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_strobe", mem_strobe, 1'b0);
    chk("rst_addr", mem_addr, 30'h0);
    chk("rst_head", head_word(), 32'h0);
    chk("rst_underrun", underrun, 1'b0);
    mem_ready = 1'b0;
    wait_cnt  = 0;
    q.delete();
    m_under = 0; vprev = 0; lrprev = 0; m_pending = 0;
    m_line = '0; m_fetch = '0; m_popcnt = 0; m_pops = 0;
    prev_strobe = 0; prev_hs = 0; prev_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          pop;
    logic [31:0] head;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   n;
    int   hs0;
    bit   vs_lvl, lr_lvl;

    reset = 1'b1; vsync = 0; line_repeat = 0; fetch_next = 0;
    base_addr = '0; mem_ready = 0; mem_data = '0;
    hs_count = 0; seen110 = 0;
    @(negedge clk);
    do_reset();

    // frame start at 0x100, fill 16 words
    base_addr = 30'h100;
    step(1, 0, 0);
    hs0 = hs_count;
    n = 0;
    while (!(q.size() == 16 && !mem_strobe) && n < 300) begin step(0, 0, 0); n++; end
    if (n >= 300) timeout_fail("fill_wait");
    chk("fill_strobe_low", mem_strobe, 1'b0);
    chk("fill_words", hs_count - hs0, 16);
    chk("red_0x11", red_byte, 8'h11);
    chk("green_0x22", green_byte, 8'h22);
    chk("blue_0x33", blue_byte, 8'h33);
    chk("bright_0x44", bright_byte, 8'h44);

    tbl[0] = '{1'b1, 32'h45342312};
    tbl[1] = '{1'b0, 32'h45342312};
    tbl[2] = '{1'b1, 32'h46352413};
    tbl[3] = '{1'b1, 32'h47362514};
    tbl[4] = '{1'b0, 32'h47362514};
    tbl[5] = '{1'b1, 32'h48372615};
    tbl[6] = '{1'b1, 32'h49382716};
    tbl[7] = '{1'b0, 32'h49382716};
    for (int i = 0; i < 8; i++) begin
      step(0, 0, tbl[i].pop);
      chk("tbl_head", head_word(), tbl[i].head);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("req_0x110_seen", seen110, 1'b1);

    // finish the 80-word line, then repeat it
    n = 0;
    while (m_pops < 80 && n < 1000) begin step(0, 0, q.size() > 0); n++; end
    if (n >= 1000) timeout_fail("line_pop_wait");
    step(0, 1, 0);
    chk("repeat_flushed", head_word(), 32'h0);
    n = 0;
    while (!(mem_strobe && !m_pending) && n < 50) begin step(0, 0, 0); n++; end
    if (n >= 50) timeout_fail("repeat_req_wait");
    chk("repeat_addr", mem_addr, 30'h100);

    // vsync while a slow request is outstanding
    base_addr = 30'h200;
    lat = 3;
    n = 0;
    while (!(mem_strobe && !m_pending && !mem_ready && wait_cnt == 0) && n < 50) begin
      step(0, 0, 0); n++;
    end
    if (n >= 50) timeout_fail("slow_req_wait");
    step(1, 0, 0);
    n = 0;
    while (mem_strobe && n < 20) begin step(1, 0, 0); n++; end
    if (n >= 20) timeout_fail("drain_wait");
    chk("drain_discard_empty", head_word(), 32'h0);
    n = 0;
    while (!mem_strobe && n < 20) begin step(0, 0, 0); n++; end
    if (n >= 20) timeout_fail("post_drain_req_wait");
    chk("post_drain_addr", mem_addr, 30'h200);
    lat = 0;

    // underrun with memory stalled
    mem_hold = 1;
    base_addr = 30'h300;
    step(1, 0, 0);
    step(0, 0, 1);
    chk("underrun_set", underrun, 1'b1);
    chk("underrun_head_zero", head_word(), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("underrun_sticky", underrun, 1'b1);
    mem_hold = 0;
    step(1, 0, 0);
    chk("underrun_cleared", underrun, 1'b0);

    // push and pop together at occupancy 15
    n = 0;
    while (!(q.size() == 16 && !mem_strobe) && n < 300) begin step(0, 0, 0); n++; end
    if (n >= 300) timeout_fail("refill_wait");
    chk("full_strobe_low", mem_strobe, 1'b0);
    step(0, 0, 1);
    hs0 = hs_count;
    pop_on_ack = 1;
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    pop_on_ack = 0;
    chk("pushpop_active", (hs_count - hs0) >= 5, 1'b1);
    hs0 = hs_count;
    n = 0;
    while (mem_strobe && n < 20) begin step(0, 0, 0); n++; end
    if (n >= 20) timeout_fail("top_off_wait");
    chk("one_word_to_full", hs_count - hs0, 1);

    // reset in the middle of a transaction
    n = 0;
    while (!mem_strobe && n < 20) begin step(0, 0, 1); n++; end
    if (n >= 20) timeout_fail("mid_txn_wait");
    do_reset();

    // randomized run
    vs_lvl = 0; lr_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) vs_lvl = ~vs_lvl;
      if ($urandom_range(0, 59) == 0) lr_lvl = ~lr_lvl;
      if ($urandom_range(0, 49) == 0) base_addr = 30'($urandom());
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(0, 3);
      if ($urandom_range(0, 999) == 0) do_reset();
      step(vs_lvl, lr_lvl, $urandom_range(0, 1) == 1);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
